ball_motion: RTL and testbench

// - Upstream of the renderer. Owns the ball's position, velocity, wall/paddle bounces and miss detection.
// - Position advances once per game tick during PLAY.
// - Drives ball_on and rgb_ball, which the renderer consumes next to the paddle layers.
// - Emits one-cycle miss pulses for the score/game-state controller.

---
 rtl/pong_pkg.sv | 21 ++
 rtl/ball_motion_if.sv | 16 +
 rtl/ball_collide.sv | 44 ++++
 rtl/ball_motion.sv | 87 ++++++++
 tb/tb_ball_motion.sv | 117 +++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: screen geometry, paddle/ball constants and state encodings shared by the pong blocks.
package pong_pkg;
    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int BALL_SIZE  = 8;
    localparam int BALL_SPEED = 2;
    localparam int P1_X       = 16;
    localparam int P2_X       = 616;
    localparam int PADDLE_W   = 8;
    localparam int PADDLE_H   = 64;
    localparam int HOLD_TICKS = 500;
    localparam int X_MAX      = H_ACTIVE - BALL_SIZE;
    localparam int Y_MAX      = V_ACTIVE - BALL_SIZE;
    localparam logic [9:0] X_CTR = 10'(X_MAX / 2);
    localparam logic [9:0] Y_CTR = 10'(Y_MAX / 2);
    localparam logic signed [10:0] SPEED_S = 11'(BALL_SPEED);
    localparam logic [8:0] HOLD_LAST = 9'(HOLD_TICKS - 1);
    localparam logic [11:0] BALL_RGB = 12'hFFF;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_PLAY = 2'b01, ST_P1WIN = 2'b10, ST_P2WIN = 2'b11} game_st_e;
    typedef enum logic [1:0] {B_IDLE, B_MOVE, B_HOLD} ball_st_e;
endpackage

// File: rtl/ball_motion_if.sv
// ball_motion_if: game inputs and ball outputs between the game logic and ball_motion.
interface ball_motion_if;
    logic        tick;
    logic [9:0]  x, y;
    logic [1:0]  game_state;
    logic        sp;
    logic [9:0]  p1_y, p2_y;
    logic [9:0]  ball_x, ball_y;
    logic        ball_on;
    logic [11:0] rgb_ball;
    logic        miss_p1, miss_p2;
    modport master (output tick, x, y, game_state, sp, p1_y, p2_y,
                    input ball_x, ball_y, ball_on, rgb_ball, miss_p1, miss_p2);
    modport slave (input tick, x, y, game_state, sp, p1_y, p2_y,
                   output ball_x, ball_y, ball_on, rgb_ball, miss_p1, miss_p2);
endinterface

// File: rtl/ball_collide.sv
// ball_collide: combinational next ball position/direction with wall, paddle and miss resolution.
module ball_collide
    import pong_pkg::*;
(
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       dx,
    input  logic       dy,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_y,
    input  logic       sp,
    output logic [9:0] nxt_x,
    output logic [9:0] nxt_y,
    output logic       nxt_dx,
    output logic       nxt_dy,
    output logic       miss_p1,
    output logic       miss_p2
);
    logic signed [10:0] nx, ny;
    int ax, ay, t1, t2;
    logic hit1, hit2, wall_r;
    always_comb begin
        nx = $signed({1'b0, ball_x}) + (dx ? SPEED_S : -SPEED_S);
        ny = $signed({1'b0, ball_y}) + (dy ? SPEED_S : -SPEED_S);
        ax = int'(nx);
        ay = int'(ny);
        t1 = int'(p1_y);
        t2 = int'(p2_y);
        nxt_dy = ay < 0 ? 1'b1 : ay > Y_MAX ? 1'b0 : dy;
        ay = ay < 0 ? 0 : ay > Y_MAX ? Y_MAX : ay;
        // paddle tests use the wall-resolved y so both axes apply on a corner tick
        hit1 = !dx && ax <= P1_X + PADDLE_W && ax + BALL_SIZE > P1_X
               && ay + BALL_SIZE > t1 && ay < t1 + PADDLE_H;
        hit2 = !sp && dx && ax + BALL_SIZE >= P2_X && ax < P2_X + PADDLE_W
               && ay + BALL_SIZE > t2 && ay < t2 + PADDLE_H;
        wall_r = sp && dx && ax > X_MAX;
        miss_p1 = !hit1 && ax < 0;
        miss_p2 = !hit2 && !sp && ax > X_MAX;
        nxt_dx = hit1 ? 1'b1 : (hit2 || wall_r) ? 1'b0 : dx;
        ax = hit1 ? P1_X + PADDLE_W : hit2 ? P2_X - BALL_SIZE : wall_r ? X_MAX : ax;
        nxt_x = 10'(ax);
        nxt_y = 10'(ay);
    end
endmodule

// File: rtl/ball_motion.sv
// ball_motion: ball position FSM (idle/move/hold), miss pulses and zero-latency ball_on decode.
module ball_motion
    import pong_pkg::*;
(
    input logic          clk,
    input logic          reset,
    ball_motion_if.slave bus
);
    ball_st_e state_q, state_d;
    logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic dx_q, dx_d, dy_q, dy_d;
    logic [8:0] hold_q, hold_d;
    logic miss_p1_q, miss_p1_d, miss_p2_q, miss_p2_d;
    logic [9:0] nxt_x, nxt_y;
    logic nxt_dx, nxt_dy, c_miss_p1, c_miss_p2, play;
    ball_collide u_collide (
        .ball_x(ball_x_q), .ball_y(ball_y_q), .dx(dx_q), .dy(dy_q),
        .p1_y(bus.p1_y), .p2_y(bus.p2_y), .sp(bus.sp),
        .nxt_x(nxt_x), .nxt_y(nxt_y), .nxt_dx(nxt_dx), .nxt_dy(nxt_dy),
        .miss_p1(c_miss_p1), .miss_p2(c_miss_p2)
    );
    always_comb begin
        play = bus.game_state == ST_PLAY;
        state_d = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dx_d = dx_q;
        dy_d = dy_q;
        hold_d = hold_q;
        miss_p1_d = 1'b0;
        miss_p2_d = 1'b0;
        if (!play) begin
            state_d = B_IDLE;
            ball_x_d = X_CTR;
            ball_y_d = Y_CTR;
            hold_d = '0;
        end else if (state_q == B_IDLE) begin
            state_d = B_MOVE;
        end else if (state_q == B_MOVE && bus.tick) begin
            if (c_miss_p1 || c_miss_p2) begin
                state_d = B_HOLD;
                hold_d = '0;
                miss_p1_d = c_miss_p1;
                miss_p2_d = c_miss_p2;
            end else begin
                ball_x_d = nxt_x;
                ball_y_d = nxt_y;
                dx_d = nxt_dx;
                dy_d = nxt_dy;
            end
        end else if (state_q == B_HOLD && bus.tick) begin
            // dx was left untouched on the miss tick, so it already serves toward the loser
            hold_d = hold_q == HOLD_LAST ? '0 : hold_q + 9'd1;
            state_d = hold_q == HOLD_LAST ? B_MOVE : B_HOLD;
            ball_x_d = hold_q == HOLD_LAST ? X_CTR : ball_x_q;
            ball_y_d = hold_q == HOLD_LAST ? Y_CTR : ball_y_q;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= B_IDLE;
            ball_x_q <= X_CTR;
            ball_y_q <= Y_CTR;
            dx_q <= 1'b1;
            dy_q <= 1'b1;
            hold_q <= '0;
            miss_p1_q <= 1'b0;
            miss_p2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            hold_q <= hold_d;
            miss_p1_q <= miss_p1_d;
            miss_p2_q <= miss_p2_d;
        end
    end
    assign bus.ball_x = ball_x_q;
    assign bus.ball_y = ball_y_q;
    assign bus.miss_p1 = miss_p1_q;
    assign bus.miss_p2 = miss_p2_q;
    assign bus.rgb_ball = BALL_RGB;
    assign bus.ball_on = bus.x >= ball_x_q && {1'b0, bus.x} < {1'b0, ball_x_q} + 11'(BALL_SIZE)
                      && bus.y >= ball_y_q && {1'b0, bus.y} < {1'b0, ball_y_q} + 11'(BALL_SIZE);
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed openers then randomized play against a rule-level ball model.
module tb_ball_motion;
    import pong_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    ball_motion_if bus();
    ball_motion dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    int n_checks = 0, n_errors = 0;
    int mx, my, mdx, mdy, mmode, mhold, mserve;
    logic mm1, mm2;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic void model_reset();
        mx = 316; my = 236; mdx = 1; mdy = 1; mmode = 0; mhold = 0; mserve = 1; mm1 = 0; mm2 = 0;
    endfunction
    // one game tick of flight: walls, paddles, right wall in single player, misses
    function automatic void model_move();
        int nx = mx + 2 * mdx, ny = my + 2 * mdy, ndx = mdx, ndy = mdy;
        int p1 = int'(bus.p1_y), p2 = int'(bus.p2_y);
        bit vert1, vert2;
        if (ny < 0) begin ny = 0; ndy = 1; end
        if (ny > 472) begin ny = 472; ndy = -1; end
        vert1 = ny + 8 > p1 && ny < p1 + 64;
        vert2 = ny + 8 > p2 && ny < p2 + 64;
        if (mdx < 0 && nx <= 24 && nx > 8 && vert1) begin nx = 24; ndx = 1; end
        else if (!bus.sp && mdx > 0 && nx >= 608 && nx < 624 && vert2) begin nx = 608; ndx = -1; end
        else if (bus.sp && nx > 632) begin nx = 632; ndx = -1; end
        else if (nx < 0 || nx > 632) begin
            mm1 = nx < 0; mm2 = nx > 632; mserve = nx < 0 ? -1 : 1; mmode = 2; mhold = 0;
            return;
        end
        mx = nx; my = ny; mdx = ndx; mdy = ndy;
    endfunction
    function automatic void model_edge();
        mm1 = 0; mm2 = 0;
        if (reset) model_reset();
        else if (bus.game_state != 2'b01) begin mmode = 0; mx = 316; my = 236; end
        else if (mmode == 0) mmode = 1;
        else if (bus.tick && mmode == 1) model_move();
        else if (bus.tick && mhold == 499) begin mmode = 1; mhold = 0; mx = 316; my = 236; mdx = mserve; end
        else if (bus.tick) mhold++;
    endfunction
    function automatic logic [9:0] pad();
        int v = $urandom_range(0, 3) != 0 ? my - int'($urandom_range(0, 60)) : int'($urandom_range(0, 479));
        return 10'(v < 0 ? 0 : v);
    endfunction
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("ball_x", 32'(bus.ball_x), mx);
        chk("ball_y", 32'(bus.ball_y), my);
        chk("miss_p1", 32'(bus.miss_p1), 32'(mm1));
        chk("miss_p2", 32'(bus.miss_p2), 32'(mm2));
        chk("rgb_ball", 32'(bus.rgb_ball), 32'h0FFF);
    endtask
    task automatic check_reset();
        chk("rst_x", 32'(bus.ball_x), 316);
        chk("rst_y", 32'(bus.ball_y), 236);
        chk("rst_state", 32'(dut.state_q), 32'(B_IDLE));
        chk("rst_miss", 32'({bus.miss_p1, bus.miss_p2}), 0);
    endtask
    initial begin
        bus.tick = 0; bus.x = 0; bus.y = 0; bus.game_state = 2'b00; bus.sp = 0;
        bus.p1_y = 200; bus.p2_y = 200;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        reset = 0;
        for (int i = 312; i < 328; i++) begin
            bus.x = 10'(i); bus.y = 10'd240;
            #1;
            chk("scan_x", 32'(bus.ball_on), 32'(i >= 316 && i <= 323));
        end
        for (int i = 232; i < 248; i++) begin
            bus.x = 10'd320; bus.y = 10'(i);
            #1;
            chk("scan_y", 32'(bus.ball_on), 32'(i >= 236 && i <= 243));
        end
        bus.game_state = 2'b01;
        step();
        bus.tick = 1;
        repeat (10) step();
        chk("free_x", 32'(bus.ball_x), 336);
        chk("free_y", 32'(bus.ball_y), 256);
        for (int c = 0; c < 24000; c++) begin
            if (c % 4000 == 3999) bus.sp = ~bus.sp;
            bus.tick = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 2499) == 0) bus.game_state = 2'($urandom_range(0, 3));
            else if (bus.game_state != 2'b01 && $urandom_range(0, 3) == 0) bus.game_state = 2'b01;
            if ($urandom_range(0, 15) == 0) bus.p1_y = pad();
            if ($urandom_range(0, 15) == 0) bus.p2_y = pad();
            bus.x = 10'(mx + int'($urandom_range(0, 12)) - 2);
            bus.y = 10'(my + int'($urandom_range(0, 12)) - 2);
            #1;
            chk("ball_on", 32'(bus.ball_on), 32'(int'(bus.x) >= mx && int'(bus.x) < mx + 8
                                                && int'(bus.y) >= my && int'(bus.y) < my + 8));
            if ($urandom_range(0, 2999) == 0) begin
                reset = 1;
                #1;
                check_reset();
                model_reset();
            end
            step();
            reset = 0;
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
